imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the instruction BRAM (4096 words).
REQ-002 SHALL have parameter CNT_W, default 16, width of the loaded-word counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port fetch_req  input  1  fetch stage requests the instruction at fetch_addr.
REQ-006 SHALL have port fetch_addr  input  32  fetch byte address (PC).
REQ-007 SHALL have port fetch_rvalid  output  1  fetch_rdata is valid this cycle.
REQ-008 SHALL have port fetch_rdata  output  32  fetched instruction word.
REQ-009 SHALL have port cpu_hold  output  1  core stalls while high.
REQ-010 SHALL have port core_restart  output  1  one-cycle pulse: core resets PC to 0.
REQ-011 SHALL have port ld_session  input  1  loader requests memory ownership while high.
REQ-012 SHALL have port ld_valid / ld_ready  input / output  1 / 1  loader transaction handshake.
REQ-013 SHALL have port ld_we  input  1  1 = write, 0 = read.
REQ-014 SHALL have port ld_addr / ld_wdata  input  32 / 32  loader byte address and write data.
REQ-015 SHALL have port ld_rvalid / ld_rdata / ld_err  output  1 / 32 / 1  loader read-return, data, out-of-range pulse.
REQ-016 SHALL have port ld_count  output  CNT_W  words written this session.
REQ-017 SHALL have port mem_en / mem_we / mem_addr / mem_wdata / mem_rdata  out / out / out / out / in  1 / 1 / ADDR_W / 32 / 32  BRAM port, 1-cycle read latency.

Function
REQ-018 SHALL implement states FETCH, DRAIN, LOAD, RELEASE.
REQ-019 In FETCH: mem_en=fetch_req, mem_we=0, mem_addr=fetch_addr[ADDR_W+1:2]; fetch_rvalid=1 exactly one cycle after an accepted fetch_req, with fetch_rdata=mem_rdata.
REQ-020 FETCH->DRAIN when ld_session=1; a fetch_req in that same cycle is still served and returns in DRAIN.
REQ-021 DRAIN lasts one cycle, memory idle; ->LOAD if ld_session=1, else ->RELEASE.
REQ-022 cpu_hold SHALL be 1 in DRAIN, LOAD, RELEASE and 0 in FETCH; fetch_req ignored outside FETCH.
REQ-023 In LOAD: ld_ready=1; ld_ready=0 in all other states; ld_valid without ld_ready is dropped.
REQ-024 Accepted write in range: mem_en=1, mem_we=1 same cycle; ld_count increments, saturating at all-ones.
REQ-025 Out-of-range (ld_addr[31:ADDR_W+2] nonzero or ld_addr[1:0] nonzero): no memory access; ld_err pulses next cycle; ld_count unchanged.
REQ-026 Accepted read in range: ld_rvalid=1 next cycle with ld_rdata=mem_rdata.
REQ-027 LOAD->RELEASE when ld_session=0; a transaction with ld_valid=1 in that cycle is dropped.
REQ-028 RELEASE lasts one cycle, memory idle, core_restart=1; ->FETCH; ld_count clears on next LOAD entry.
REQ-029 fetch_rdata and ld_rdata SHALL hold last value when their valid is low.

Reset
REQ-030 rst SHALL force state FETCH and all outputs 0 (cpu_hold, core_restart, fetch_rvalid, ld_ready, ld_rvalid, ld_err, ld_count, mem_en, mem_we), discarding any in-flight read.
REQ-031 rst mid-LOAD SHALL not pulse core_restart.

Configuration
REQ-032 With IMEM_READBACK_EN defined, loader reads behave per REQ-026.
REQ-033 Without IMEM_READBACK_EN, accepted loader reads SHALL not access memory and SHALL return ld_rvalid=1, ld_rdata=0 next cycle.

Verification
REQ-034 Fetch 0x0, 0x4, 0x8 back-to-back, BRAM preloaded 0x13,0x93,0x113 -> fetch_rvalid cycles 1-3 with those words, cpu_hold=0.
REQ-035 ld_session rises with fetch_req at 0x10 -> that fetch returns in DRAIN; cpu_hold=1 from next cycle; ld_ready=1 two cycles later.
REQ-036 Write 0xDEADBEEF to 0x40, read 0x40 -> mem_addr=0x10, ld_rdata=0xDEADBEEF (macro on) or 0 (off); ld_count=1.
REQ-037 Write to 0x4000 and 0x41 -> ld_err pulses twice, mem_we never 1, ld_count unchanged.
REQ-038 ld_session falls -> one RELEASE cycle with core_restart=1, then FETCH, cpu_hold=0.
REQ-039 rst asserted mid-LOAD after 3 writes -> next cycle FETCH, all outputs 0, no core_restart.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction BRAM between the core fetch stage and a loader.
// Define IMEM_READBACK_EN to let the loader read BRAM back; otherwise loader reads return zero.
module imem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_rvalid,
    output logic [31:0]       fetch_rdata,
    output logic              cpu_hold,
    output logic              core_restart,
    input  logic              ld_session,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    output logic              ld_err,
    output logic [CNT_W-1:0]  ld_count,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef IMEM_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    typedef enum logic [1:0] {FETCH, DRAIN, LOAD, RELEASE} state_t;

    state_t      state;
    logic        ld_accept;
    logic        ld_in_range;
    logic [31:0] fetch_rdata_p1;
    logic [31:0] ld_rdata_p1;
    logic        unused_fetch_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign ld_in_range       = (ld_addr[31:ADDR_W+2] == '0) && (ld_addr[1:0] == 2'b00);
    assign ld_accept         = (state == LOAD) && ld_session && ld_valid;
    assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

    // Stage p0: BRAM request, combinational from state and the requesting side.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = fetch_addr[ADDR_W+1:2];
        mem_wdata = ld_wdata;
        if (!rst) begin
            if (state == FETCH) begin
                mem_en = fetch_req;
            end else if (state == LOAD) begin
                mem_addr = ld_addr[ADDR_W+1:2];
                mem_en   = ld_accept && ld_in_range && (ld_we || READBACK);
                mem_we   = ld_accept && ld_in_range && ld_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            cpu_hold     <= 1'b0;
            core_restart <= 1'b0;
            ld_ready     <= 1'b0;
            fetch_rvalid <= 1'b0;
            ld_rvalid    <= 1'b0;
            ld_err       <= 1'b0;
            ld_count     <= '0;
        end else begin
            fetch_rvalid <= (state == FETCH) && fetch_req;
            ld_rvalid    <= ld_accept && ld_in_range && !ld_we;
            ld_err       <= ld_accept && !ld_in_range;
            core_restart <= 1'b0;
            case (state)
                FETCH: begin
                    if (ld_session) begin
                        state    <= DRAIN;
                        cpu_hold <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (ld_session) begin
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                        ld_count <= '0;
                    end else begin
                        state        <= RELEASE;
                        core_restart <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!ld_session) begin
                        state        <= RELEASE;
                        ld_ready     <= 1'b0;
                        core_restart <= 1'b1;
                    end else if (ld_accept && ld_in_range && ld_we) begin
                        ld_count <= sat_inc(ld_count);
                    end
                end
                RELEASE: begin
                    state    <= FETCH;
                    cpu_hold <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Stage p1: read data returns one cycle after the request; last value is held otherwise.
    assign fetch_rdata = fetch_rvalid ? mem_rdata : fetch_rdata_p1;
    assign ld_rdata    = ld_rvalid ? (READBACK ? mem_rdata : 32'h0) : ld_rdata_p1;

    always_ff @(posedge clk) begin
        if (fetch_rvalid) fetch_rdata_p1 <= mem_rdata;
        if (ld_rvalid)    ld_rdata_p1    <= ld_rdata;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: BRAM model plus a shadow-memory reference model.
module tb_imem_arbiter;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;
`ifdef IMEM_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, fetch_req, ld_session, ld_valid, ld_we;
    logic [31:0]       fetch_addr, ld_addr, ld_wdata;
    logic              fetch_rvalid, cpu_hold, core_restart, ld_ready, ld_rvalid, ld_err;
    logic [31:0]       fetch_rdata, ld_rdata;
    logic [CNT_W-1:0]  ld_count;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    logic [31:0] bram      [0:4095];
    logic [31:0] model_mem [0:4095];
    bit          preloaded = 1'b0;
    int          nvec = 0;
    int          nerr = 0;
    int          exp_count = 0;

    imem_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .cpu_hold(cpu_hold),
        .core_restart(core_restart), .ld_session(ld_session), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err), .ld_count(ld_count),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // BRAM with one-cycle read latency, preloaded from the model on the first edge.
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 4096; i++) bram[i] <= model_mem[i];
            preloaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            mem_rdata <= bram[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic bit addr_ok(input logic [31:0] a);
        return (a < 32'h4000) && (a % 4 == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; ld_session = 1'b0; ld_valid = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        step(); step();
        nvec++; if ({cpu_hold, core_restart, fetch_rvalid, ld_ready, ld_rvalid, ld_err, mem_en, mem_we} !== 8'h0) begin
            nerr++; $display("FAIL reset_flags got=%b exp=00000000", {cpu_hold, core_restart, fetch_rvalid, ld_ready, ld_rvalid, ld_err, mem_en, mem_we});
        end
        nvec++; if (ld_count !== '0) begin nerr++; $display("FAIL reset_count got=%0d exp=0", ld_count); end
        rst = 1'b0;
        step();
        nvec++; if (cpu_hold !== 1'b0 || ld_ready !== 1'b0) begin
            nerr++; $display("FAIL post_reset_state got hold=%b ready=%b exp 0 0", cpu_hold, ld_ready);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] exp [0:2];
        exp[0] = 32'h13; exp[1] = 32'h93; exp[2] = 32'h113;
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'b1; fetch_addr = 32'(4 * i);
            #1;
            nvec++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'(i)) begin
                nerr++; $display("FAIL fetch_req_port[%0d] got en=%b we=%b addr=%h exp 1 0 %h", i, mem_en, mem_we, mem_addr, i);
            end
            step();
            nvec++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== exp[i] || cpu_hold !== 1'b0) begin
                nerr++; $display("FAIL fetch_word[%0d] got v=%b d=%h hold=%b exp 1 %h 0", i, fetch_rvalid, fetch_rdata, cpu_hold, exp[i]);
            end
        end
        fetch_req = 1'b0;
        step();
        nvec++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h113) begin
            nerr++; $display("FAIL fetch_hold got v=%b d=%h exp 0 00000113", fetch_rvalid, fetch_rdata);
        end
    endtask

    task automatic test_random_fetch();
        bit          r;
        logic [31:0] a, e;
        for (int i = 0; i < 24; i++) begin
            r = 1'($urandom_range(0, 1)); a = $urandom;
            fetch_req = r; fetch_addr = a;
            step();
            nvec++; if (fetch_rvalid !== r) begin
                nerr++; $display("FAIL rnd_fetch_valid[%0d] got=%b exp=%b", i, fetch_rvalid, r);
            end
            if (r) begin
                e = model_mem[(a >> 2) % 4096];
                nvec++; if (fetch_rdata !== e) begin
                    nerr++; $display("FAIL rnd_fetch_data[%0d] got=%h exp=%h", i, fetch_rdata, e);
                end
            end
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_drain();
        fetch_req = 1'b1; fetch_addr = 32'h10; ld_session = 1'b1;
        step();
        nvec++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== model_mem[4] || cpu_hold !== 1'b1 || ld_ready !== 1'b0) begin
            nerr++; $display("FAIL drain_cycle got v=%b d=%h hold=%b rdy=%b exp 1 %h 1 0", fetch_rvalid, fetch_rdata, cpu_hold, ld_ready, model_mem[4]);
        end
        #1;
        nvec++; if (mem_en !== 1'b0) begin nerr++; $display("FAIL drain_mem_idle got=%b exp=0", mem_en); end
        step();
        fetch_req = 1'b0;
        exp_count = 0;
        nvec++; if (ld_ready !== 1'b1 || cpu_hold !== 1'b1 || fetch_rvalid !== 1'b0 || ld_count !== '0) begin
            nerr++; $display("FAIL load_entry got rdy=%b hold=%b fv=%b cnt=%0d exp 1 1 0 0", ld_ready, cpu_hold, fetch_rvalid, ld_count);
        end
    endtask

    task automatic test_load_rw();
        logic [31:0] e;
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 32'h40; ld_wdata = 32'hDEADBEEF;
        #1;
        nvec++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h10 || mem_wdata !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL ld_write_port got en=%b we=%b addr=%h wd=%h exp 1 1 010 deadbeef", mem_en, mem_we, mem_addr, mem_wdata);
        end
        step();
        model_mem[16] = 32'hDEADBEEF; exp_count = 1;
        nvec++; if (ld_count !== 16'(exp_count) || ld_err !== 1'b0 || ld_rvalid !== 1'b0) begin
            nerr++; $display("FAIL ld_write_result got cnt=%0d err=%b rv=%b exp 1 0 0", ld_count, ld_err, ld_rvalid);
        end
        ld_we = 1'b0;
        #1;
        nvec++; if (mem_en !== READBACK || mem_we !== 1'b0) begin
            nerr++; $display("FAIL ld_read_port got en=%b we=%b exp %b 0", mem_en, mem_we, READBACK);
        end
        step();
        ld_valid = 1'b0;
        e = READBACK ? 32'hDEADBEEF : 32'h0;
        nvec++; if (ld_rvalid !== 1'b1 || ld_rdata !== e || ld_count !== 16'(exp_count)) begin
            nerr++; $display("FAIL ld_read_result got rv=%b d=%h cnt=%0d exp 1 %h 1", ld_rvalid, ld_rdata, ld_count, e);
        end
        step();
        nvec++; if (ld_rvalid !== 1'b0 || ld_rdata !== e) begin
            nerr++; $display("FAIL ld_rdata_hold got rv=%b d=%h exp 0 %h", ld_rvalid, ld_rdata, e);
        end
    endtask

    task automatic test_errors();
        logic [31:0] bad [0:1];
        bad[0] = 32'h4000; bad[1] = 32'h41;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_we = 1'b1; ld_addr = bad[i]; ld_wdata = 32'h12345678;
            #1;
            nvec++; if (mem_we !== 1'b0 || mem_en !== 1'b0) begin
                nerr++; $display("FAIL err_no_access[%0d] got en=%b we=%b exp 0 0", i, mem_en, mem_we);
            end
            step();
            ld_valid = 1'b0;
            nvec++; if (ld_err !== 1'b1 || ld_count !== 16'(exp_count)) begin
                nerr++; $display("FAIL err_pulse[%0d] got err=%b cnt=%0d exp 1 %0d", i, ld_err, ld_count, exp_count);
            end
            step();
            nvec++; if (ld_err !== 1'b0) begin nerr++; $display("FAIL err_clear[%0d] got=%b exp=0", i, ld_err); end
        end
    endtask

    task automatic test_random_load();
        logic [31:0] a, d, e;
        bit          v, w, ok;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 3) != 0); w = 1'($urandom_range(0, 1)); d = $urandom;
            case ($urandom_range(0, 5))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(0, 4095) * 4 + $urandom_range(1, 3));
                default: a = 32'($urandom_range(0, 4095) * 4);
            endcase
            ok = addr_ok(a);
            ld_valid = v; ld_we = w; ld_addr = a; ld_wdata = d;
            #1;
            nvec++; if (mem_we !== (v && w && ok)) begin
                nerr++; $display("FAIL rnd_ld_we[%0d] got=%b exp=%b", i, mem_we, v && w && ok);
            end
            step();
            if (v && w && ok) begin
                model_mem[a >> 2] = d;
                if (exp_count < 65535) exp_count++;
            end
            nvec++; if (ld_err !== (v && !ok) || ld_rvalid !== (v && !w && ok)) begin
                nerr++; $display("FAIL rnd_ld_flags[%0d] got err=%b rv=%b exp %b %b", i, ld_err, ld_rvalid, v && !ok, v && !w && ok);
            end
            if (v && !w && ok) begin
                e = READBACK ? model_mem[a >> 2] : 32'h0;
                nvec++; if (ld_rdata !== e) begin
                    nerr++; $display("FAIL rnd_ld_rdata[%0d] got=%h exp=%h", i, ld_rdata, e);
                end
            end
            nvec++; if (ld_count !== 16'(exp_count)) begin
                nerr++; $display("FAIL rnd_ld_count[%0d] got=%0d exp=%0d", i, ld_count, exp_count);
            end
        end
        ld_valid = 1'b0;
        step();
    endtask

    task automatic test_release();
        ld_session = 1'b0; ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 32'h80; ld_wdata = 32'hCAFEF00D;
        #1;
        nvec++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            nerr++; $display("FAIL release_drop got en=%b we=%b exp 0 0", mem_en, mem_we);
        end
        step();
        ld_valid = 1'b0;
        nvec++; if (core_restart !== 1'b1 || cpu_hold !== 1'b1 || ld_ready !== 1'b0 || ld_err !== 1'b0 || ld_count !== 16'(exp_count)) begin
            nerr++; $display("FAIL release_cycle got rs=%b hold=%b rdy=%b err=%b cnt=%0d exp 1 1 0 0 %0d", core_restart, cpu_hold, ld_ready, ld_err, ld_count, exp_count);
        end
        fetch_req = 1'b1; fetch_addr = 32'h0;
        #1;
        nvec++; if (mem_en !== 1'b0) begin nerr++; $display("FAIL release_ignores_fetch got=%b exp=0", mem_en); end
        step();
        nvec++; if (core_restart !== 1'b0 || cpu_hold !== 1'b0 || fetch_rvalid !== 1'b0) begin
            nerr++; $display("FAIL back_to_fetch got rs=%b hold=%b fv=%b exp 0 0 0", core_restart, cpu_hold, fetch_rvalid);
        end
        fetch_addr = 32'h80;
        step();
        fetch_req = 1'b0;
        nvec++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== model_mem[32]) begin
            nerr++; $display("FAIL dropped_write_check got v=%b d=%h exp 1 %h", fetch_rvalid, fetch_rdata, model_mem[32]);
        end
        step();
    endtask

    task automatic test_drain_abort();
        ld_session = 1'b1;
        step();
        ld_session = 1'b0;
        nvec++; if (cpu_hold !== 1'b1) begin nerr++; $display("FAIL abort_drain_hold got=%b exp=1", cpu_hold); end
        step();
        nvec++; if (core_restart !== 1'b1 || ld_ready !== 1'b0 || ld_count !== 16'(exp_count)) begin
            nerr++; $display("FAIL abort_release got rs=%b rdy=%b cnt=%0d exp 1 0 %0d", core_restart, ld_ready, ld_count, exp_count);
        end
        step();
        nvec++; if (core_restart !== 1'b0 || cpu_hold !== 1'b0) begin
            nerr++; $display("FAIL abort_fetch got rs=%b hold=%b exp 0 0", core_restart, cpu_hold);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] a, d;
        ld_session = 1'b1;
        step(); step();
        exp_count = 0;
        nvec++; if (ld_ready !== 1'b1 || ld_count !== '0) begin
            nerr++; $display("FAIL reentry_clear got rdy=%b cnt=%0d exp 1 0", ld_ready, ld_count);
        end
        for (int i = 0; i < 3; i++) begin
            a = 32'($urandom_range(0, 4095) * 4); d = $urandom;
            ld_valid = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdata = d;
            step();
            model_mem[a >> 2] = d; exp_count++;
        end
        ld_valid = 1'b0;
        nvec++; if (ld_count !== 16'd3) begin nerr++; $display("FAIL three_writes got=%0d exp=3", ld_count); end
        rst = 1'b1; ld_session = 1'b0;
        step();
        nvec++; if ({cpu_hold, core_restart, fetch_rvalid, ld_ready, ld_rvalid, ld_err, mem_en, mem_we} !== 8'h0 || ld_count !== '0) begin
            nerr++; $display("FAIL mid_load_reset got flags=%b cnt=%0d exp 00000000 0", {cpu_hold, core_restart, fetch_rvalid, ld_ready, ld_rvalid, ld_err, mem_en, mem_we}, ld_count);
        end
        rst = 1'b0;
        step();
        nvec++; if (core_restart !== 1'b0 || cpu_hold !== 1'b0) begin
            nerr++; $display("FAIL mid_load_no_restart got rs=%b hold=%b exp 0 0", core_restart, cpu_hold);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model_mem[i] = $urandom;
        model_mem[0] = 32'h13; model_mem[1] = 32'h93; model_mem[2] = 32'h113;
        test_reset();
        test_fetch();
        test_random_fetch();
        test_drain();
        test_load_rw();
        test_errors();
        test_random_load();
        test_release();
        test_drain_abort();
        test_reset_mid_load();
        test_random_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
